spi_input_conditioner: RTL
==========================

// Module: spi_input_conditioner
// PURPOSE
//   Front end that sits directly upstream of the SPI control fsm.
//   Brings the asynchronous pins sclk_pin, cs_pin and mosi_pin into the clk domain.
//   Each pin passes through a synchronizer, then a stability (glitch) filter.
//   Produces clean levels plus one-cycle edge pulses. The fsm and the shift
//   register advance on sclk_posedge / sclk_negedge, never on raw sclk_pin.
// PARAMETERS
//   SYNC_STAGES    2  flip-flops in each synchronizer chain; legal range >= 2
//   WAIT_TIME      3  consecutive clk cycles a new synced level must persist before it is accepted; legal range >= 1
//   COUNTER_WIDTH  3  width of each stability counter; must hold WAIT_TIME-1, checked at elaboration ($error)
// PORTS
//   clk           in   1  system clock; all state updates on the rising edge
//   reset         in   1  synchronous, active-high reset
//   sclk_pin      in   1  raw SPI clock, asynchronous
//   cs_pin        in   1  raw chip select, active-low, asynchronous
//   mosi_pin      in   1  raw SPI data in, asynchronous
//   sclk_cond     out  1  filtered sclk level
//   sclk_posedge  out  1  one-cycle pulse when sclk_cond goes 0->1
//   sclk_negedge  out  1  one-cycle pulse when sclk_cond goes 1->0
//   cs_cond       out  1  filtered cs level
//   cs_falling    out  1  one-cycle pulse when cs_cond goes 1->0 (transaction start)
//   cs_rising     out  1  one-cycle pulse when cs_cond goes 0->1 (transaction end)
//   mosi_cond     out  1  filtered mosi level
// BEHAVIOUR
//   Channels: three identical, independent channels (sclk, cs, mosi).
//     Simultaneous pin changes are handled per channel with no interaction.
//   Reset (reset=1 at a clk edge):
//     Sync FFs and conditioned level load the idle values: sclk 0, cs 1, mosi 0.
//     Stability counters clear to 0; all pulses drive 0.
//     Reset has priority over every other event, including a pending acceptance.
//     Leaving reset never generates a pulse by itself.
//   Synchronizer: sync_out is the value of the last FF in the chain; a pin level
//     reaches sync_out on the SYNC_STAGES-th clk edge after it is first sampled.
//   Filter, evaluated on each clk edge:
//     sync_out == cond        -> cnt <= 0; no pulse
//     sync_out != cond, cnt < WAIT_TIME-1
//                             -> cnt <= cnt+1
//     sync_out != cond, cnt == WAIT_TIME-1
//                             -> cond <= sync_out; cnt <= 0; pulse for that direction
//   Glitch: if sync_out returns to cond before acceptance, cnt clears.
//     A later change restarts the full WAIT_TIME count.
//   Latency: number the first clk edge that samples a new, stable pin level as edge 1.
//     cond and its pulse change at edge SYNC_STAGES+WAIT_TIME (defaults: edge 5).
//   Pulses: registered; high for exactly the one cycle in which cond has its new value.
//     posedge and negedge (falling and rising for cs) are mutually exclusive.
//     Minimum spacing between pulses on one channel is WAIT_TIME cycles.
//   mosi has no pulse outputs; its level only.
//   Pin toggling faster than once per WAIT_TIME cycles: cond never changes. This is required.
//   Pin held at a non-idle level through reset release (e.g. cs_pin=0): that channel
//     accepts it at edge SYNC_STAGES+WAIT_TIME after release, with its pulse.
// TESTING
//   1 Reset: hold sclk_pin=1, cs_pin=0, reset=1 for 3 cycles
//     -> sclk_cond=0, cs_cond=1, all pulses 0 during reset.
//     After release: sclk_posedge and cs_falling both pulse at edge 5, and only once.
//   2 Clean edge: sclk_pin 0->1, held high
//     -> sclk_cond=1 and sclk_posedge=1 at edge 5 only.
//     Then sclk_pin 1->0 -> sclk_negedge at edge 5 only.
//   3 Glitch reject: sclk_pin high for 2 clk cycles, then low for 20
//     -> sclk_cond stays 0; no pulse on any channel.
//   4 Retrigger: mosi_pin high for 2 cycles, low for 1, then high held
//     -> mosi_cond rises at edge 5 counted from the second rising sample, not the first.
//   5 Simultaneous: cs_pin 1->0 and mosi_pin 0->1 on the same cycle
//     -> cs_falling pulses and mosi_cond rises on the same edge 5; cs_rising stays 0.
//   6 Reset mid-count: sclk_pin 0->1, reset=1 on edge 3
//     -> no sclk_posedge, cnt=0, sclk_cond=0.
//     After release with the pin still high: posedge at edge 5 after release.

Source files
------------

// File: rtl/spi_input_conditioner.sv
// spi_input_conditioner: synchronizes and glitch-filters the SPI pins into clean levels and edge pulses
module spi_input_conditioner #(
   parameter int SYNC_STAGES   = 2,
   parameter int WAIT_TIME     = 3,
   parameter int COUNTER_WIDTH = 3
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_sclk_pin,
   input  logic i_cs_pin,
   input  logic i_mosi_pin,
   output logic o_sclk_cond,
   output logic o_sclk_posedge,
   output logic o_sclk_negedge,
   output logic o_cs_cond,
   output logic o_cs_falling,
   output logic o_cs_rising,
   output logic o_mosi_cond
);
   localparam logic [2:0] IDLE = 3'b010;
   localparam logic [COUNTER_WIDTH-1:0] LAST = COUNTER_WIDTH'(WAIT_TIME - 1);
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
   end
   if (WAIT_TIME < 1 || WAIT_TIME - 1 >= 2 ** COUNTER_WIDTH) begin : g_bad_wait
      $error("COUNTER_WIDTH cannot hold WAIT_TIME-1");
   end
   logic [2:0] w_pin, w_cond;
   logic [1:0] w_rise, w_fall;
   assign w_pin = {i_mosi_pin, i_cs_pin, i_sclk_pin};
   for (genvar c = 0; c < 3; c++) begin : g_ch
      logic [SYNC_STAGES-1:0]   r_sync;
      logic [COUNTER_WIDTH-1:0] r_cnt;
      logic r_cond, w_out, w_diff, w_done;
      assign w_out  = r_sync[SYNC_STAGES-1];
      assign w_diff = w_out != r_cond;
      assign w_done = w_diff && r_cnt == LAST;
      assign w_cond[c] = r_cond;
      always_ff @(posedge i_clk) begin
         if (i_reset) begin
            r_sync <= {SYNC_STAGES{IDLE[c]}};
            r_cnt  <= '0;
            r_cond <= IDLE[c];
         end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_pin[c]};
            r_cnt  <= (w_diff && !w_done) ? r_cnt + 1'b1 : '0;
            r_cond <= w_done ? w_out : r_cond;
         end
      end
      // mosi is level-only, so pulse registers exist for sclk and cs alone
      if (c < 2) begin : g_pulse
         logic r_rise, r_fall;
         assign w_rise[c] = r_rise;
         assign w_fall[c] = r_fall;
         always_ff @(posedge i_clk) begin
            if (i_reset) begin
               r_rise <= 1'b0;
               r_fall <= 1'b0;
            end else begin
               r_rise <= w_done && w_out;
               r_fall <= w_done && !w_out;
            end
         end
      end
   end
   assign o_sclk_cond    = w_cond[0];
   assign o_sclk_posedge = w_rise[0];
   assign o_sclk_negedge = w_fall[0];
   assign o_cs_cond      = w_cond[1];
   assign o_cs_falling   = w_fall[1];
   assign o_cs_rising    = w_rise[1];
   assign o_mosi_cond    = w_cond[2];
endmodule
